pspin_ingress_dma_mc: RTL and testbench

PSPIN_INGRESS_DMA_MC -- requirements
Module: pspin_ingress_dma_mc

---
 rtl/pspin_ingress_dma_mc.sv | 170 +++++++++++++++++
 tb/tb_pspin_ingress_dma_mc.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pspin_ingress_dma_mc.sv
// Ingress DMA master controller: allocates a packet buffer per incoming frame,
// issues a write descriptor, streams the frame to the write engine, then reports a completion.
module pspin_ingress_dma_mc #(
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 8,
    parameter int AXIS_USER_WIDTH = 97,
    parameter int ADDR_WIDTH      = 32,
    parameter int LEN_WIDTH       = 16,
    parameter int MAX_PKT_LEN     = 1536,
    parameter int STAT_WIDTH      = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_rx_tdata,
    input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_rx_tkeep,
    input  logic                       s_axis_rx_tvalid,
    output logic                       s_axis_rx_tready,
    input  logic                       s_axis_rx_tlast,
    input  logic [AXIS_DEST_WIDTH-1:0] s_axis_rx_tdest,
    input  logic [AXIS_USER_WIDTH-1:0] s_axis_rx_tuser,

    output logic                       m_alloc_req_valid,
    input  logic                       m_alloc_req_ready,
    output logic [AXIS_DEST_WIDTH-1:0] m_alloc_req_dest,

    input  logic                       s_alloc_resp_valid,
    output logic                       s_alloc_resp_ready,
    input  logic [ADDR_WIDTH-1:0]      s_alloc_resp_addr,
    input  logic                       s_alloc_resp_err,

    output logic                       m_wr_desc_valid,
    input  logic                       m_wr_desc_ready,
    output logic [ADDR_WIDTH-1:0]      m_wr_desc_addr,

    output logic [AXIS_DATA_WIDTH-1:0] m_axis_wr_tdata,
    output logic [AXIS_KEEP_WIDTH-1:0] m_axis_wr_tkeep,
    output logic                       m_axis_wr_tvalid,
    input  logic                       m_axis_wr_tready,
    output logic                       m_axis_wr_tlast,

    output logic                       m_cpl_valid,
    input  logic                       m_cpl_ready,
    output logic [ADDR_WIDTH-1:0]      m_cpl_addr,
    output logic [LEN_WIDTH-1:0]       m_cpl_len,
    output logic [AXIS_DEST_WIDTH-1:0] m_cpl_dest,
    output logic [AXIS_USER_WIDTH-1:0] m_cpl_user,
    output logic                       m_cpl_trunc,

    output logic [STAT_WIDTH-1:0]      stat_frames,
    output logic [STAT_WIDTH-1:0]      stat_drops
);

    typedef enum logic [2:0] {
        IDLE, ALLOC_REQ, ALLOC_WAIT, DESC, STREAM, DRAIN, DROP, CPL
    } state_t;

    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_PKT_LEN);

    state_t                     state;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [AXIS_DEST_WIDTH-1:0] dest_q;
    logic [AXIS_USER_WIDTH-1:0] user_q;
    logic [LEN_WIDTH-1:0]       len_q;
    logic                       trunc_q;

    logic [LEN_WIDTH-1:0]       beat_bytes;
    logic [LEN_WIDTH-1:0]       len_next;
    logic                       trunc_hit;
    logic                       rx_fire;

    always_comb begin
        beat_bytes = '0;
        for (int unsigned i = 0; i < AXIS_KEEP_WIDTH; i++) begin
            beat_bytes = beat_bytes + LEN_WIDTH'(s_axis_rx_tkeep[i]);
        end
    end

    assign len_next  = len_q + beat_bytes;
    assign rx_fire   = s_axis_rx_tvalid && s_axis_rx_tready;
    // A non-last beat that fills the buffer closes the written frame early.
    assign trunc_hit = (state == STREAM) && !s_axis_rx_tlast && (len_next >= MAX_LEN);

    assign s_axis_rx_tready = (state == STREAM) ? m_axis_wr_tready
                                                : ((state == DRAIN) || (state == DROP));

    assign m_axis_wr_tdata  = s_axis_rx_tdata;
    assign m_axis_wr_tkeep  = s_axis_rx_tkeep;
    assign m_axis_wr_tvalid = (state == STREAM) && s_axis_rx_tvalid;
    assign m_axis_wr_tlast  = s_axis_rx_tlast || trunc_hit;

    assign m_alloc_req_valid  = (state == ALLOC_REQ);
    assign m_alloc_req_dest   = dest_q;
    assign s_alloc_resp_ready = (state == ALLOC_WAIT);
    assign m_wr_desc_valid    = (state == DESC);
    assign m_wr_desc_addr     = addr_q;

    assign m_cpl_valid = (state == CPL);
    assign m_cpl_addr  = addr_q;
    assign m_cpl_len   = len_q;
    assign m_cpl_dest  = dest_q;
    assign m_cpl_user  = user_q;
    assign m_cpl_trunc = trunc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_q      <= '0;
            dest_q      <= '0;
            user_q      <= '0;
            len_q       <= '0;
            trunc_q     <= 1'b0;
            stat_frames <= '0;
            stat_drops  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Peek at the first beat for routing info; it is consumed later in STREAM.
                    if (s_axis_rx_tvalid) begin
                        dest_q  <= s_axis_rx_tdest;
                        user_q  <= s_axis_rx_tuser;
                        len_q   <= '0;
                        trunc_q <= 1'b0;
                        state   <= ALLOC_REQ;
                    end
                end
                ALLOC_REQ: if (m_alloc_req_ready) state <= ALLOC_WAIT;
                ALLOC_WAIT: begin
                    if (s_alloc_resp_valid) begin
                        if (s_alloc_resp_err) begin
                            state <= DROP;
                        end else begin
                            addr_q <= s_alloc_resp_addr;
                            state  <= DESC;
                        end
                    end
                end
                DESC: if (m_wr_desc_ready) state <= STREAM;
                STREAM: begin
                    if (rx_fire) begin
                        len_q <= len_next;
                        if (s_axis_rx_tlast) begin
                            state <= CPL;
                        end else if (len_next >= MAX_LEN) begin
                            trunc_q <= 1'b1;
                            state   <= DRAIN;
                        end
                    end
                end
                DRAIN: if (rx_fire && s_axis_rx_tlast) state <= CPL;
                DROP: begin
                    if (rx_fire && s_axis_rx_tlast) begin
                        stat_drops <= stat_drops + 1'b1;
                        state      <= IDLE;
                    end
                end
                CPL: begin
                    if (m_cpl_ready) begin
                        stat_frames <= stat_frames + 1'b1;
                        trunc_q     <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pspin_ingress_dma_mc.sv
// Self-checking bench for pspin_ingress_dma_mc: table-driven frame vectors plus
// hand-written stall and mid-frame reset sequences.
module tb_pspin_ingress_dma_mc;

    localparam int DW = 512, KW = 64, DESTW = 8, UW = 97, AW = 32, LW = 16, SW = 32;
    localparam int MAXL = 1536;

    logic clk, rst;
    logic [DW-1:0]    s_axis_rx_tdata;
    logic [KW-1:0]    s_axis_rx_tkeep;
    logic             s_axis_rx_tvalid, s_axis_rx_tready, s_axis_rx_tlast;
    logic [DESTW-1:0] s_axis_rx_tdest;
    logic [UW-1:0]    s_axis_rx_tuser;
    logic             m_alloc_req_valid, m_alloc_req_ready;
    logic [DESTW-1:0] m_alloc_req_dest;
    logic             s_alloc_resp_valid, s_alloc_resp_ready, s_alloc_resp_err;
    logic [AW-1:0]    s_alloc_resp_addr;
    logic             m_wr_desc_valid, m_wr_desc_ready;
    logic [AW-1:0]    m_wr_desc_addr;
    logic [DW-1:0]    m_axis_wr_tdata;
    logic [KW-1:0]    m_axis_wr_tkeep;
    logic             m_axis_wr_tvalid, m_axis_wr_tready, m_axis_wr_tlast;
    logic             m_cpl_valid, m_cpl_ready, m_cpl_trunc;
    logic [AW-1:0]    m_cpl_addr;
    logic [LW-1:0]    m_cpl_len;
    logic [DESTW-1:0] m_cpl_dest;
    logic [UW-1:0]    m_cpl_user;
    logic [SW-1:0]    stat_frames, stat_drops;

    pspin_ingress_dma_mc #(
        .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_DEST_WIDTH(DESTW),
        .AXIS_USER_WIDTH(UW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW),
        .MAX_PKT_LEN(MAXL), .STAT_WIDTH(SW)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_rx_tdata(s_axis_rx_tdata), .s_axis_rx_tkeep(s_axis_rx_tkeep),
        .s_axis_rx_tvalid(s_axis_rx_tvalid), .s_axis_rx_tready(s_axis_rx_tready),
        .s_axis_rx_tlast(s_axis_rx_tlast), .s_axis_rx_tdest(s_axis_rx_tdest),
        .s_axis_rx_tuser(s_axis_rx_tuser),
        .m_alloc_req_valid(m_alloc_req_valid), .m_alloc_req_ready(m_alloc_req_ready),
        .m_alloc_req_dest(m_alloc_req_dest),
        .s_alloc_resp_valid(s_alloc_resp_valid), .s_alloc_resp_ready(s_alloc_resp_ready),
        .s_alloc_resp_addr(s_alloc_resp_addr), .s_alloc_resp_err(s_alloc_resp_err),
        .m_wr_desc_valid(m_wr_desc_valid), .m_wr_desc_ready(m_wr_desc_ready),
        .m_wr_desc_addr(m_wr_desc_addr),
        .m_axis_wr_tdata(m_axis_wr_tdata), .m_axis_wr_tkeep(m_axis_wr_tkeep),
        .m_axis_wr_tvalid(m_axis_wr_tvalid), .m_axis_wr_tready(m_axis_wr_tready),
        .m_axis_wr_tlast(m_axis_wr_tlast),
        .m_cpl_valid(m_cpl_valid), .m_cpl_ready(m_cpl_ready), .m_cpl_addr(m_cpl_addr),
        .m_cpl_len(m_cpl_len), .m_cpl_dest(m_cpl_dest), .m_cpl_user(m_cpl_user),
        .m_cpl_trunc(m_cpl_trunc),
        .stat_frames(stat_frames), .stat_drops(stat_drops)
    );

    typedef struct {
        logic [31:0]    tag;
        logic [KW-1:0]  keep;
        logic           last;
        logic [DESTW-1:0] dest;
        logic [UW-1:0]  user;
    } beat_t;

    typedef struct {
        logic [31:0]   tag;
        logic [KW-1:0] keep;
        logic          last;
    } fwd_t;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [LW-1:0]    len;
        logic [DESTW-1:0] dest;
        logic [UW-1:0]    user;
        logic             trunc;
    } cpl_t;

    typedef struct {
        int          nbeats;
        logic [KW-1:0] last_keep;
        logic        err;
        logic [AW-1:0] addr;
        int          delay;
        int          exp_fwd;
        int          exp_len;
        logic        exp_trunc;
    } vec_t;

    // Source frames: main writes entries and src_wr, the source process owns src_rd.
    beat_t src_mem [0:255];
    int    src_wr = 0;
    int    src_rd;

    // Monitor-owned observations.
    fwd_t  fwd_q[$];
    cpl_t  cpl_q[$];
    int    consumed, req_fires, desc_fires, wait_viol, cpl_viol;
    logic [AW-1:0]    last_desc_addr;
    logic [DESTW-1:0] last_req_dest;
    bit    src_fire, req_fire, resp_fire;

    // Main-owned controls.
    logic [AW-1:0] alloc_addr;
    logic          alloc_err;
    int            alloc_delay;
    bit            rand_rdy, wr_hold;
    int            passed, total;

    bit  alloc_pend;
    int  dly;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got running required finished");
        $fatal(1);
    end

    // Monitor: samples handshakes on the falling edge, i.e. transfers at the next rising edge.
    initial begin
        consumed = 0; req_fires = 0; desc_fires = 0; wait_viol = 0; cpl_viol = 0;
        last_desc_addr = '0; last_req_dest = '0;
        forever begin
            @(negedge clk);
            src_fire = 0; req_fire = 0; resp_fire = 0;
            if (!rst) begin
                src_fire  = s_axis_rx_tvalid && s_axis_rx_tready;
                req_fire  = m_alloc_req_valid && m_alloc_req_ready;
                resp_fire = s_alloc_resp_valid && s_alloc_resp_ready;
                if (src_fire) consumed++;
                if (req_fire) begin
                    req_fires++;
                    last_req_dest = m_alloc_req_dest;
                end
                if (m_wr_desc_valid && m_wr_desc_ready) begin
                    desc_fires++;
                    last_desc_addr = m_wr_desc_addr;
                end
                if (m_axis_wr_tvalid && m_axis_wr_tready)
                    fwd_q.push_back('{m_axis_wr_tdata[31:0], m_axis_wr_tkeep, m_axis_wr_tlast});
                if (m_cpl_valid && m_cpl_ready)
                    cpl_q.push_back('{m_cpl_addr, m_cpl_len, m_cpl_dest, m_cpl_user, m_cpl_trunc});
                if ((alloc_pend || s_alloc_resp_valid) && s_axis_rx_tready) wait_viol++;
                if (m_cpl_valid && s_axis_rx_tready) cpl_viol++;
            end
        end
    end

    // Frame source.
    initial begin
        src_rd = 0;
        s_axis_rx_tvalid = 1'b0; s_axis_rx_tdata = '0; s_axis_rx_tkeep = '0;
        s_axis_rx_tlast = 1'b0; s_axis_rx_tdest = '0; s_axis_rx_tuser = '0;
        forever begin
            @(posedge clk); #1;
            if (src_fire) src_rd++;
            if (src_rd < src_wr) begin
                s_axis_rx_tvalid = 1'b1;
                s_axis_rx_tdata  = {16{src_mem[src_rd].tag}};
                s_axis_rx_tkeep  = src_mem[src_rd].keep;
                s_axis_rx_tlast  = src_mem[src_rd].last;
                s_axis_rx_tdest  = src_mem[src_rd].dest;
                s_axis_rx_tuser  = src_mem[src_rd].user;
            end else begin
                s_axis_rx_tvalid = 1'b0;
            end
        end
    end

    // Allocator model: answers each request after alloc_delay extra cycles.
    initial begin
        s_alloc_resp_valid = 1'b0; s_alloc_resp_addr = '0; s_alloc_resp_err = 1'b0;
        alloc_pend = 0; dly = 0;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                s_alloc_resp_valid = 1'b0;
                alloc_pend = 0;
            end else begin
                if (resp_fire) s_alloc_resp_valid = 1'b0;
                if (req_fire) begin
                    alloc_pend = 1;
                    dly = alloc_delay;
                end else if (alloc_pend) begin
                    if (dly == 0) begin
                        s_alloc_resp_valid = 1'b1;
                        s_alloc_resp_addr  = alloc_addr;
                        s_alloc_resp_err   = alloc_err;
                        alloc_pend = 0;
                    end else begin
                        dly--;
                    end
                end
            end
        end
    end

    // Write-data sink.
    initial begin
        m_axis_wr_tready = 1'b0;
        forever begin
            @(posedge clk); #1;
            m_axis_wr_tready = wr_hold ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk); #2;
        end
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    function automatic logic [UW-1:0] user_of(input int i);
        return {1'b1, 32'(i), 64'hDEAD_BEEF_0000_0000 | 64'(i)};
    endfunction

    task automatic push_frame(input int n, input logic [KW-1:0] last_keep,
                              input logic [DESTW-1:0] dest, input logic [UW-1:0] user,
                              input logic [15:0] ftag);
        for (int b = 0; b < n; b++) begin
            src_mem[src_wr] = '{{ftag, 16'(b)}, (b == n - 1) ? last_keep : {KW{1'b1}},
                                (b == n - 1), dest, user};
            src_wr++;
        end
    endtask

    // Count forwarded beats from fwd_q[base] that differ from tag/keep/last expectations.
    function automatic int fwd_errs(input int base, input int cnt, input logic [15:0] ftag,
                                    input int first, input int nbeats, input logic [KW-1:0] last_keep);
        int errs = 0;
        for (int k = 0; k < cnt; k++) begin
            if (base + k >= fwd_q.size()) begin
                errs++;
            end else begin
                if (fwd_q[base + k].tag !== {ftag, 16'(first + k)}) errs++;
                if (fwd_q[base + k].last !== (k == cnt - 1)) errs++;
                if (fwd_q[base + k].keep !== ((first + k == nbeats - 1) ? last_keep : {KW{1'b1}})) errs++;
            end
        end
        return errs;
    endfunction

    vec_t vecs [7];
    int   exp_frames, exp_drops;

    initial begin
        int fb, cb, c0, r0, d0, w0, v0, t, rem, first;
        passed = 0; total = 0; exp_frames = 0; exp_drops = 0;
        alloc_addr = '0; alloc_err = 1'b0; alloc_delay = 0; rand_rdy = 0; wr_hold = 0;
        m_alloc_req_ready = 1'b1; m_wr_desc_ready = 1'b1; m_cpl_ready = 1'b1;

        vecs[0] = '{3,  64'h0000_0000_0000_000F, 1'b0, 32'h1000, 0,  3,  132,  1'b0};
        vecs[1] = '{3,  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h2000, 20, 3,  192,  1'b0};
        vecs[2] = '{5,  64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'h3000, 0,  0,  0,    1'b0};
        vecs[3] = '{40, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h4000, 0,  24, 1536, 1'b1};
        vecs[4] = '{24, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h5000, 0,  24, 1536, 1'b0};
        vecs[5] = '{1,  64'h0000_0000_0000_0000, 1'b0, 32'h6000, 0,  1,  0,    1'b0};
        vecs[6] = '{1,  64'h0000_0000_0000_0001, 1'b0, 32'h7000, 0,  1,  1,    1'b0};

        rst = 1'b1;
        tick(3);
        chk("rst_rx_tready",   s_axis_rx_tready, 0);
        chk("rst_alloc_valid", m_alloc_req_valid, 0);
        chk("rst_resp_ready",  s_alloc_resp_ready, 0);
        chk("rst_desc_valid",  m_wr_desc_valid, 0);
        chk("rst_wr_tvalid",   m_axis_wr_tvalid, 0);
        chk("rst_cpl_valid",   m_cpl_valid, 0);
        chk("rst_cpl_len",     m_cpl_len, 0);
        chk("rst_stat_frames", stat_frames, 0);
        chk("rst_stat_drops",  stat_drops, 0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 7; i++) begin
            alloc_addr = vecs[i].addr; alloc_err = vecs[i].err; alloc_delay = vecs[i].delay;
            fb = fwd_q.size(); cb = cpl_q.size(); c0 = consumed; r0 = req_fires;
            d0 = desc_fires; w0 = wait_viol;
            push_frame(vecs[i].nbeats, vecs[i].last_keep, DESTW'(8'h10 + i), user_of(i), 16'(i));
            t = 0;
            while (!(src_rd == src_wr && (vecs[i].err || cpl_q.size() > cb)) && t < 400) begin
                tick();
                t++;
            end
            tick(3);
            if (vecs[i].err) exp_drops++; else exp_frames++;
            chk($sformatf("v%0d_timeout", i), t >= 400, 0);
            chk($sformatf("v%0d_consumed", i), consumed - c0, vecs[i].nbeats);
            chk($sformatf("v%0d_fwd_count", i), fwd_q.size() - fb, vecs[i].exp_fwd);
            chk($sformatf("v%0d_fwd_data", i),
                fwd_errs(fb, vecs[i].exp_fwd, 16'(i), 0, vecs[i].nbeats, vecs[i].last_keep), 0);
            chk($sformatf("v%0d_req_count", i), req_fires - r0, 1);
            chk($sformatf("v%0d_req_dest", i), last_req_dest, 8'h10 + i);
            chk($sformatf("v%0d_wait_tready", i), wait_viol - w0, 0);
            chk($sformatf("v%0d_desc_count", i), desc_fires - d0, vecs[i].err ? 0 : 1);
            chk($sformatf("v%0d_cpl_count", i), cpl_q.size() - cb, vecs[i].err ? 0 : 1);
            if (!vecs[i].err && cpl_q.size() > cb) begin
                chk($sformatf("v%0d_desc_addr", i), last_desc_addr, vecs[i].addr);
                chk($sformatf("v%0d_cpl_addr", i), cpl_q[cb].addr, vecs[i].addr);
                chk($sformatf("v%0d_cpl_len", i), cpl_q[cb].len, vecs[i].exp_len);
                chk($sformatf("v%0d_cpl_trunc", i), cpl_q[cb].trunc, vecs[i].exp_trunc);
                chk($sformatf("v%0d_cpl_dest", i), cpl_q[cb].dest, 8'h10 + i);
                chk($sformatf("v%0d_cpl_user", i), cpl_q[cb].user, user_of(i));
            end
            chk($sformatf("v%0d_stat_frames", i), stat_frames, exp_frames);
            chk($sformatf("v%0d_stat_drops", i), stat_drops, exp_drops);
        end

        // Completion stall with a random write-side ready: second frame must wait.
        rand_rdy = 1; m_cpl_ready = 1'b0; alloc_addr = 32'h8000; alloc_err = 1'b0; alloc_delay = 0;
        fb = fwd_q.size(); cb = cpl_q.size(); c0 = consumed; r0 = req_fires; v0 = cpl_viol;
        push_frame(4, 64'h0000_0000_0000_00FF, 8'h20, user_of(32), 16'h20);
        push_frame(2, 64'h0000_0000_0000_0003, 8'h21, user_of(33), 16'h21);
        t = 0;
        while (!m_cpl_valid && t < 400) begin
            tick();
            t++;
        end
        chk("stall_timeout_a", t >= 400, 0);
        tick(10);
        chk("stall_cpl_held", m_cpl_valid, 1);
        chk("stall_cpl_len",  m_cpl_len, 200);
        chk("stall_req_count", req_fires - r0, 1);
        chk("stall_consumed", consumed - c0, 4);
        m_cpl_ready = 1'b1;
        t = 0;
        while (cpl_q.size() < cb + 2 && t < 400) begin
            tick();
            t++;
        end
        tick(3);
        exp_frames += 2;
        chk("stall_timeout_b", t >= 400, 0);
        chk("stall_req_total", req_fires - r0, 2);
        chk("stall_tready_in_cpl", cpl_viol - v0, 0);
        chk("stall_fwd_a", fwd_errs(fb, 4, 16'h20, 0, 4, 64'h0000_0000_0000_00FF), 0);
        chk("stall_fwd_b", fwd_errs(fb + 4, 2, 16'h21, 0, 2, 64'h0000_0000_0000_0003), 0);
        if (cpl_q.size() >= cb + 2) begin
            chk("stall_len_a",  cpl_q[cb].len, 200);
            chk("stall_len_b",  cpl_q[cb + 1].len, 66);
            chk("stall_dest_b", cpl_q[cb + 1].dest, 8'h21);
        end
        chk("stall_stat_frames", stat_frames, exp_frames);
        rand_rdy = 0;

        // Reset while streaming: remaining beats become a fresh frame.
        alloc_addr = 32'h9000;
        fb = fwd_q.size(); c0 = src_wr;
        push_frame(4, 64'hFFFF_FFFF_FFFF_FFFF, 8'h30, user_of(48), 16'h30);
        t = 0;
        while (fwd_q.size() == fb && t < 400) begin
            tick();
            t++;
        end
        chk("rst_mid_timeout", t >= 400, 0);
        wr_hold = 1;
        tick(2);
        chk("rst_mid_streaming", m_axis_wr_tvalid, 1);
        rem = src_wr - src_rd;
        first = src_rd - c0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("rst_mid_wr_tvalid",   m_axis_wr_tvalid, 0);
        chk("rst_mid_rx_tready",   s_axis_rx_tready, 0);
        chk("rst_mid_alloc_valid", m_alloc_req_valid, 0);
        chk("rst_mid_desc_valid",  m_wr_desc_valid, 0);
        chk("rst_mid_cpl_valid",   m_cpl_valid, 0);
        chk("rst_mid_stat_frames", stat_frames, 0);
        tick(2);
        wr_hold = 0; rst = 1'b0; exp_frames = 0; exp_drops = 0;
        fb = fwd_q.size(); cb = cpl_q.size(); r0 = req_fires;
        t = 0;
        while (cpl_q.size() == cb && t < 400) begin
            tick();
            t++;
        end
        tick(3);
        exp_frames++;
        chk("rst_new_timeout", t >= 400, 0);
        chk("rst_new_req", req_fires - r0, 1);
        chk("rst_new_fwd_count", fwd_q.size() - fb, rem);
        chk("rst_new_fwd_data", fwd_errs(fb, rem, 16'h30, first, 4, 64'hFFFF_FFFF_FFFF_FFFF), 0);
        if (cpl_q.size() > cb) begin
            chk("rst_new_cpl_len", cpl_q[cb].len, rem * 64);
            chk("rst_new_cpl_addr", cpl_q[cb].addr, 32'h9000);
        end
        chk("rst_new_stat_frames", stat_frames, exp_frames);
        chk("rst_new_stat_drops", stat_drops, exp_drops);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
